// File: rtl/cmd_pkg.sv
// Shared types and constants for the keypad command decoder.
package cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } cmdState_t;

  localparam int MODE_REJECT   = 0;
  localparam int MODE_PRIORITY = 1;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser followed by a stability counter.
// The debounced level flips only after the synchronised level has disagreed
// with it on DEBOUNCE+1 consecutive edges, so shorter glitches never reach it.
module btn_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          syncA;
  logic          syncB;
  logic [CW-1:0] count;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= btnRaw;
      syncB <= syncA;
    end
  end

  // Count disagreeing cycles; any agreement restarts the count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      deb   <= 1'b0;
    end else if (syncB == deb) begin
      count <= '0;
    end else if (count == CW'(DEBOUNCE)) begin
      deb   <= syncB;
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_decoder.sv
// Debounced one-hot keypad command decoder: one pulse per press, multi-key
// presses either rejected with an error or resolved by lowest index.
module cmd_decoder
  import cmd_pkg::*;
#(
  parameter int CH       = 4,
  parameter int DEBOUNCE = 4,
  parameter int MODE     = MODE_REJECT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         btn_in,
  input  logic                  err_clr,
  output logic                  cmd_valid,
  output logic [CH-1:0]         cmd_onehot,
  output logic [$clog2(CH)-1:0] cmd_code,
  output logic                  err,
  output logic                  err_flag,
  output logic                  busy
);

  localparam int CW = $clog2(CH);
  localparam int PW = $clog2(CH + 1);

  logic [CH-1:0] deb;
  logic [PW-1:0] popCount;
  logic [CW-1:0] lowIdx;
  logic [CH-1:0] lowHot;
  logic [CH-1:0] ownerMask;
  logic [CH-1:0] ownerNext;

  cmdState_t     state;
  cmdState_t     nextState;
  logic          validNext;
  logic [CH-1:0] hotNext;
  logic [CW-1:0] codeNext;
  logic          errNext;

  for (genvar g = 0; g < CH; g++) begin : gChannel
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) uDebounce (
      .clk    (clk),
      .rst    (rst),
      .btnRaw (btn_in[g]),
      .deb    (deb[g])
    );
  end

  // Count pressed keys and find the lowest pressed index (and its one-hot).
  always_comb begin
    popCount = '0;
    lowIdx   = '0;
    lowHot   = '0;
    for (int i = 0; i < CH; i++) begin
      popCount = popCount + PW'(deb[i]);
    end
    for (int i = CH - 1; i >= 0; i--) begin
      if (deb[i]) begin
        lowIdx    = CW'(i);
        lowHot    = '0;
        lowHot[i] = 1'b1;
      end
    end
  end

  // Next state and next registered outputs of the press-handling FSM.
  always_comb begin
    nextState = state;
    validNext = 1'b0;
    hotNext   = '0;
    codeNext  = '0;
    errNext   = 1'b0;
    ownerNext = ownerMask;
    unique case (state)
      IDLE: begin
        if (popCount == PW'(1) || (popCount > PW'(1) && MODE == MODE_PRIORITY)) begin
          validNext = 1'b1;
          hotNext   = lowHot;
          codeNext  = lowIdx;
          ownerNext = lowHot;
          nextState = ACTIVE;
        end else if (popCount > PW'(1)) begin
          errNext   = 1'b1;
          nextState = ERROR;
        end
      end
      ACTIVE: begin
        if (popCount == '0) begin
          nextState = IDLE;
        end else if (MODE == MODE_REJECT && (deb & ~ownerMask) != '0) begin
          errNext   = 1'b1;
          nextState = ERROR;
        end
      end
      ERROR: begin
        if (popCount == '0) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State and output registers; the sticky flag keeps priority over a clear
  // in both the cycle an error is detected and the cycle its pulse is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ownerMask  <= '0;
      cmd_valid  <= 1'b0;
      cmd_onehot <= '0;
      cmd_code   <= '0;
      err        <= 1'b0;
      err_flag   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nextState;
      ownerMask  <= ownerNext;
      cmd_valid  <= validNext;
      cmd_onehot <= hotNext;
      cmd_code   <= codeNext;
      err        <= errNext;
      err_flag   <= errNext | err | (err_flag & ~err_clr);
      busy       <= (nextState != IDLE);
    end
  end

endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Parametrised, debounced one-hot command decoder for the keypad front end. It samples CH asynchronous button lines, synchronises and debounces each one, and emits exactly one single-cycle command pulse per press. It flags illegal multi-key presses, or resolves them by priority, and holds off further commands until all keys are released. Its outputs feed the calculator datapath control.

## Interface
- CH, 4: number of button channels (≥2).
- DEBOUNCE, 4: consecutive stable cycles required to change a debounced level (≥1).
- MODE, 0: multi-press policy.
  - 0: reject with error.
  - 1: lowest index wins, no error.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  CH  raw button levels, asynchronous, active high.
- err_clr  in  1  synchronous clear of err_flag.
- cmd_valid  out  1  single-cycle pulse: a command was accepted.
- cmd_onehot  out  CH  one-hot command; all zero when cmd_valid=0.
- cmd_code  out  $clog2(CH)  binary index of the command; 0 when cmd_valid=0.
- err  out  1  single-cycle pulse on an illegal press.
- err_flag  out  1  sticky error.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- Per channel, a 2-flop synchroniser produces s. A debounce counter increments while s≠deb and resets to 0 when s==deb. When the counter reaches DEBOUNCE, deb takes the value of s and the counter resets.
- Let P be the number of deb bits that are high.
- FSM states are IDLE, ACTIVE and ERROR. All outputs are registered.
- IDLE:
  - P==1: pulse cmd_valid with that channel's index; go to ACTIVE.
  - P>1 and MODE=0: pulse err; go to ERROR.
  - P>1 and MODE=1: pulse cmd_valid with the lowest set index; go to ACTIVE.
- ACTIVE:
  - P==0: go to IDLE.
  - A deb bit other than the accepted channel rises while MODE=0: pulse err; go to ERROR.
  - In MODE=1, additional presses are ignored.
  - No command is issued while in ACTIVE.
- ERROR: go to IDLE only when P==0. No commands are issued.
- err_flag is set by err and cleared by err_clr. If both occur in the same cycle, set wins.
- A channel that releases and re-presses without all channels reaching 0 produces no new command.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchronisers, deb and counters all 0.
- Reset asserted mid-operation aborts immediately; no pulse is emitted after deassertion until a fresh debounced press.
- Latency: raw btn_in stable high from edge 0 gives deb high after edge DEBOUNCE+2 and cmd_valid high in the cycle after edge DEBOUNCE+3.
- Release latency is the same; busy falls one cycle after deb reaches all zero.
- Glitches shorter than DEBOUNCE cycles at the synchroniser output are fully rejected.
- Presses on two channels whose deb bits rise on the same edge count as simultaneous (P>1 in IDLE).
- Presses one or more cycles apart are handled by the ACTIVE rule.
- cmd_valid and err are never high in the same cycle.
- Each pulse lasts exactly one cycle.

## Structure
- Shared package cmd_pkg:
  - FSM state enum (IDLE, ACTIVE, ERROR).
  - MODE_REJECT=0 and MODE_PRIORITY=1 constants.
- Sub-module btn_debounce (one channel: synchroniser plus counter, parameter DEBOUNCE), instantiated CH times with a generate loop.
- Priority encoder and popcount stay in the top level.

## Test plan
All scenarios use CH=4, DEBOUNCE=4.
- Reset: hold btn_in=4'b0010 across a rst pulse -> all outputs 0 during reset; after release, a single cmd_valid with code 1 at DEBOUNCE+3 edges after rst falls.
- Single press of btn_in[2] held 20 cycles -> exactly one cmd_valid, cmd_onehot=4'b0100, cmd_code=2; busy high until 7 cycles after release.
- Glitch of 3 cycles on btn_in[0] -> no cmd_valid, busy stays 0.
- MODE=0, btn_in=4'b1001 applied simultaneously -> err pulse, err_flag=1, no cmd_valid.
  - After release, a press of btn_in[3] -> cmd_code=3.
  - err_clr -> err_flag=0.
- MODE=1, btn_in=4'b1010 applied simultaneously -> cmd_valid with cmd_code=1, err stays 0.
- MODE=0, press btn_in[0], then btn_in[1] 10 cycles later while [0] is held -> one cmd (code 0), then an err pulse.
  - err_clr asserted in the same cycle as err -> err_flag=1.
